// File: rtl/amba_axi4lite_arbiter.sv
// NUM_M-to-1 AXI4-Lite arbiter with independent write and read paths, one outstanding each.
// Define AXI4L_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins); default is round robin.
module amba_axi4lite_arbiter #(
    parameter int unsigned NUM_M      = 2,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                          ACLK,
    input  logic                          ARESETn,
    // Manager side
    input  logic [NUM_M*ADDR_WIDTH-1:0]   M_AWADDR,
    input  logic [NUM_M*3-1:0]            M_AWPROT,
    input  logic [NUM_M-1:0]              M_AWVALID,
    output logic [NUM_M-1:0]              M_AWREADY,
    input  logic [NUM_M*DATA_WIDTH-1:0]   M_WDATA,
    input  logic [NUM_M*STRB_WIDTH-1:0]   M_WSTRB,
    input  logic [NUM_M-1:0]              M_WVALID,
    output logic [NUM_M-1:0]              M_WREADY,
    output logic [NUM_M*2-1:0]            M_BRESP,
    output logic [NUM_M-1:0]              M_BVALID,
    input  logic [NUM_M-1:0]              M_BREADY,
    input  logic [NUM_M*ADDR_WIDTH-1:0]   M_ARADDR,
    input  logic [NUM_M*3-1:0]            M_ARPROT,
    input  logic [NUM_M-1:0]              M_ARVALID,
    output logic [NUM_M-1:0]              M_ARREADY,
    output logic [NUM_M*DATA_WIDTH-1:0]   M_RDATA,
    output logic [NUM_M*2-1:0]            M_RRESP,
    output logic [NUM_M-1:0]              M_RVALID,
    input  logic [NUM_M-1:0]              M_RREADY,
    // Subordinate side
    output logic [ADDR_WIDTH-1:0]         S_AWADDR,
    output logic [2:0]                    S_AWPROT,
    output logic                          S_AWVALID,
    input  logic                          S_AWREADY,
    output logic [DATA_WIDTH-1:0]         S_WDATA,
    output logic [STRB_WIDTH-1:0]         S_WSTRB,
    output logic                          S_WVALID,
    input  logic                          S_WREADY,
    input  logic [1:0]                    S_BRESP,
    input  logic                          S_BVALID,
    output logic                          S_BREADY,
    output logic [ADDR_WIDTH-1:0]         S_ARADDR,
    output logic [2:0]                    S_ARPROT,
    output logic                          S_ARVALID,
    input  logic                          S_ARREADY,
    input  logic [DATA_WIDTH-1:0]         S_RDATA,
    input  logic [1:0]                    S_RRESP,
    input  logic                          S_RVALID,
    output logic                          S_RREADY,
    // Debug grants
    output logic [NUM_M-1:0]              WR_GNT,
    output logic [NUM_M-1:0]              RD_GNT
);

    localparam int unsigned IW = $clog2(NUM_M);

    typedef enum logic [1:0] {WrIdle, WrAddr, WrResp} wr_state_e;
    typedef enum logic [1:0] {RdIdle, RdAddr, RdData} rd_state_e;

    wr_state_e       wr_state;
    rd_state_e       rd_state;
    logic [IW-1:0]   wr_idx;
    logic [IW-1:0]   rd_idx;
    logic [IW-1:0]   wr_ptr;
    logic [IW-1:0]   rd_ptr;
    logic [IW-1:0]   wr_pick;
    logic [IW-1:0]   rd_pick;
    logic            aw_done;
    logic            w_done;

    // First requester at or after ptr; with ptr tied to 0 this is fixed priority.
    function automatic logic [IW-1:0] rr_pick(input logic [NUM_M-1:0] req,
                                               input logic [IW-1:0]    ptr);
        logic [IW-1:0] pick;
        logic          found;
        int unsigned   j;
        pick  = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < NUM_M; k++) begin
            j = (32'(ptr) + k) % NUM_M;
            if (!found && req[j[IW-1:0]]) begin
                found = 1'b1;
                pick  = j[IW-1:0];
            end
        end
        return pick;
    endfunction

    function automatic logic [NUM_M-1:0] to_onehot(input logic [IW-1:0] idx);
        logic [NUM_M-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

`ifdef AXI4L_ARB_FIXED_PRIO_EN
    assign wr_ptr = '0;
    assign rd_ptr = '0;
`else
    function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] idx);
        return (32'(idx) == NUM_M - 1) ? '0 : idx + 1'b1;
    endfunction
`endif

    assign wr_pick = rr_pick(M_AWVALID, wr_ptr);
    assign rd_pick = rr_pick(M_ARVALID, rd_ptr);

    // Per-manager payload views
    logic [ADDR_WIDTH-1:0] awaddr_arr [NUM_M];
    logic [2:0]            awprot_arr [NUM_M];
    logic [DATA_WIDTH-1:0] wdata_arr  [NUM_M];
    logic [STRB_WIDTH-1:0] wstrb_arr  [NUM_M];
    logic [ADDR_WIDTH-1:0] araddr_arr [NUM_M];
    logic [2:0]            arprot_arr [NUM_M];

    for (genvar i = 0; i < NUM_M; i++) begin : g_unpack
        assign awaddr_arr[i] = M_AWADDR[i*ADDR_WIDTH +: ADDR_WIDTH];
        assign awprot_arr[i] = M_AWPROT[i*3 +: 3];
        assign wdata_arr[i]  = M_WDATA[i*DATA_WIDTH +: DATA_WIDTH];
        assign wstrb_arr[i]  = M_WSTRB[i*STRB_WIDTH +: STRB_WIDTH];
        assign araddr_arr[i] = M_ARADDR[i*ADDR_WIDTH +: ADDR_WIDTH];
        assign arprot_arr[i] = M_ARPROT[i*3 +: 3];
    end

    // Write path muxing, all combinational from the registered grant
    logic wr_addr_st;
    logic wr_resp_st;
    logic aw_hs;
    logic w_hs;
    logic b_hs;

    assign wr_addr_st = (wr_state == WrAddr);
    assign wr_resp_st = (wr_state == WrResp);

    assign S_AWADDR  = wr_addr_st ? awaddr_arr[wr_idx] : '0;
    assign S_AWPROT  = wr_addr_st ? awprot_arr[wr_idx] : '0;
    assign S_AWVALID = wr_addr_st && !aw_done && M_AWVALID[wr_idx];
    assign S_WDATA   = wr_addr_st ? wdata_arr[wr_idx] : '0;
    assign S_WSTRB   = wr_addr_st ? wstrb_arr[wr_idx] : '0;
    assign S_WVALID  = wr_addr_st && !w_done && M_WVALID[wr_idx];
    assign S_BREADY  = wr_resp_st && M_BREADY[wr_idx];

    assign M_AWREADY = WR_GNT & {NUM_M{wr_addr_st && !aw_done && S_AWREADY}};
    assign M_WREADY  = WR_GNT & {NUM_M{wr_addr_st && !w_done && S_WREADY}};
    assign M_BVALID  = WR_GNT & {NUM_M{wr_resp_st && S_BVALID}};
    assign M_BRESP   = {NUM_M{S_BRESP}};

    assign aw_hs = S_AWVALID && S_AWREADY;
    assign w_hs  = S_WVALID && S_WREADY;
    assign b_hs  = S_BVALID && S_BREADY;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            wr_state <= WrIdle;
            wr_idx   <= '0;
            WR_GNT   <= '0;
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
`ifndef AXI4L_ARB_FIXED_PRIO_EN
            wr_ptr   <= '0;
`endif
        end else begin
            unique case (wr_state)
                WrIdle: begin
                    if (|M_AWVALID) begin
                        wr_state <= WrAddr;
                        wr_idx   <= wr_pick;
                        WR_GNT   <= to_onehot(wr_pick);
                    end
                end
                WrAddr: begin
                    if (aw_hs) aw_done <= 1'b1;
                    if (w_hs)  w_done  <= 1'b1;
                    if ((aw_done || aw_hs) && (w_done || w_hs)) wr_state <= WrResp;
                end
                WrResp: begin
                    if (b_hs) begin
                        wr_state <= WrIdle;
                        WR_GNT   <= '0;
                        aw_done  <= 1'b0;
                        w_done   <= 1'b0;
`ifndef AXI4L_ARB_FIXED_PRIO_EN
                        wr_ptr   <= next_idx(wr_idx);
`endif
                    end
                end
                default: wr_state <= WrIdle;
            endcase
        end
    end

    // Read path muxing
    logic rd_addr_st;
    logic rd_data_st;
    logic ar_hs;
    logic r_hs;

    assign rd_addr_st = (rd_state == RdAddr);
    assign rd_data_st = (rd_state == RdData);

    assign S_ARADDR  = rd_addr_st ? araddr_arr[rd_idx] : '0;
    assign S_ARPROT  = rd_addr_st ? arprot_arr[rd_idx] : '0;
    assign S_ARVALID = rd_addr_st && M_ARVALID[rd_idx];
    assign S_RREADY  = rd_data_st && M_RREADY[rd_idx];

    assign M_ARREADY = RD_GNT & {NUM_M{rd_addr_st && S_ARREADY}};
    assign M_RVALID  = RD_GNT & {NUM_M{rd_data_st && S_RVALID}};
    assign M_RDATA   = {NUM_M{S_RDATA}};
    assign M_RRESP   = {NUM_M{S_RRESP}};

    assign ar_hs = S_ARVALID && S_ARREADY;
    assign r_hs  = S_RVALID && S_RREADY;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            rd_state <= RdIdle;
            rd_idx   <= '0;
            RD_GNT   <= '0;
`ifndef AXI4L_ARB_FIXED_PRIO_EN
            rd_ptr   <= '0;
`endif
        end else begin
            unique case (rd_state)
                RdIdle: begin
                    if (|M_ARVALID) begin
                        rd_state <= RdAddr;
                        rd_idx   <= rd_pick;
                        RD_GNT   <= to_onehot(rd_pick);
                    end
                end
                RdAddr: begin
                    if (ar_hs) rd_state <= RdData;
                end
                RdData: begin
                    if (r_hs) begin
                        rd_state <= RdIdle;
                        RD_GNT   <= '0;
`ifndef AXI4L_ARB_FIXED_PRIO_EN
                        rd_ptr   <= next_idx(rd_idx);
`endif
                    end
                end
                default: rd_state <= RdIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_amba_axi4lite_arbiter.sv
// Directed bench for amba_axi4lite_arbiter with NUM_M=2, 32-bit address and data.
module tb_amba_axi4lite_arbiter;

    logic        clk;
    logic        rst_n;
    logic [63:0] m_awaddr, m_araddr, m_wdata, m_rdata;
    logic [5:0]  m_awprot, m_arprot;
    logic [7:0]  m_wstrb;
    logic [1:0]  m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
    logic [1:0]  m_arvalid, m_arready, m_rvalid, m_rready;
    logic [3:0]  m_bresp, m_rresp;
    logic [31:0] s_awaddr, s_wdata, s_araddr, s_rdata;
    logic [2:0]  s_awprot, s_arprot;
    logic [3:0]  s_wstrb;
    logic        s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
    logic        s_arvalid, s_arready, s_rvalid, s_rready;
    logic [1:0]  s_bresp, s_rresp;
    logic [1:0]  wr_gnt, rd_gnt;

    int total = 0;
    int bad   = 0;

    amba_axi4lite_arbiter #(.NUM_M(2), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .ACLK(clk), .ARESETn(rst_n),
        .M_AWADDR(m_awaddr), .M_AWPROT(m_awprot), .M_AWVALID(m_awvalid), .M_AWREADY(m_awready),
        .M_WDATA(m_wdata), .M_WSTRB(m_wstrb), .M_WVALID(m_wvalid), .M_WREADY(m_wready),
        .M_BRESP(m_bresp), .M_BVALID(m_bvalid), .M_BREADY(m_bready),
        .M_ARADDR(m_araddr), .M_ARPROT(m_arprot), .M_ARVALID(m_arvalid), .M_ARREADY(m_arready),
        .M_RDATA(m_rdata), .M_RRESP(m_rresp), .M_RVALID(m_rvalid), .M_RREADY(m_rready),
        .S_AWADDR(s_awaddr), .S_AWPROT(s_awprot), .S_AWVALID(s_awvalid), .S_AWREADY(s_awready),
        .S_WDATA(s_wdata), .S_WSTRB(s_wstrb), .S_WVALID(s_wvalid), .S_WREADY(s_wready),
        .S_BRESP(s_bresp), .S_BVALID(s_bvalid), .S_BREADY(s_bready),
        .S_ARADDR(s_araddr), .S_ARPROT(s_arprot), .S_ARVALID(s_arvalid), .S_ARREADY(s_arready),
        .S_RDATA(s_rdata), .S_RRESP(s_rresp), .S_RVALID(s_rvalid), .S_RREADY(s_rready),
        .WR_GNT(wr_gnt), .RD_GNT(rd_gnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    int exp_seq [6];
    int rem [2];

    initial begin
`ifdef AXI4L_ARB_FIXED_PRIO_EN
        exp_seq = '{0, 0, 0, 1, 1, 1};
`else
        exp_seq = '{0, 1, 0, 1, 0, 1};
`endif
        rem = '{3, 3};

        // Reset with every manager valid high and the subordinate fully ready
        rst_n = 1'b0;
        m_awaddr = '0; m_araddr = '0; m_wdata = '0; m_awprot = '0; m_arprot = '0;
        m_wstrb = '1;
        m_awvalid = 2'b11; m_wvalid = 2'b11; m_arvalid = 2'b11;
        m_bready = 2'b11; m_rready = 2'b11;
        s_awready = 1'b1; s_wready = 1'b1; s_arready = 1'b1;
        s_bvalid = 1'b1; s_rvalid = 1'b1; s_bresp = 2'b00; s_rresp = 2'b00; s_rdata = '0;
        step();
        step();
        chk("rst_s_valids", {s_awvalid, s_wvalid, s_arvalid, s_bready, s_rready}, 5'b0);
        chk("rst_m_readies", {m_awready, m_wready, m_arready}, 6'b0);
        chk("rst_m_valids", {m_bvalid, m_rvalid}, 4'b0);
        chk("rst_grants", {wr_gnt, rd_gnt}, 4'b0);
        chk("rst_payload", s_awaddr, 32'h0);

        m_awvalid = 2'b00; m_wvalid = 2'b00; m_arvalid = 2'b00;
        s_bvalid = 1'b0; s_rvalid = 1'b0;
        rst_n = 1'b1;
        step();

        // Single write from M1
        m_awaddr[63:32] = 32'h10;
        m_wdata[63:32]  = 32'hA5A5A5A5;
        m_awvalid = 2'b10; m_wvalid = 2'b10; m_bready = 2'b10;
        #1;
        chk("w1_arb_latency", s_awvalid, 1'b0);
        step();
        chk("w1_s_awvalid", {s_awvalid, s_wvalid}, 2'b11);
        chk("w1_s_awaddr", s_awaddr, 32'h10);
        chk("w1_s_wdata", s_wdata, 32'hA5A5A5A5);
        chk("w1_gnt", wr_gnt, 2'b10);
        chk("w1_m_readies", {m_awready, m_wready}, 4'b1010);
        step();
        m_awvalid = 2'b00; m_wvalid = 2'b00;
        s_bvalid = 1'b1; s_bresp = 2'b00;
        #1;
        chk("w1_s_bready", s_bready, 1'b1);
        chk("w1_m_bvalid", m_bvalid, 2'b10);
        chk("w1_bresp", m_bresp, 4'b0000);
        step();
        s_bvalid = 1'b0;
        #1;
        chk("w1_idle_gnt", wr_gnt, 2'b00);
        chk("w1_idle_bvalid", m_bvalid, 2'b00);

        // Both managers issue three back-to-back writes
        m_awaddr = {32'h200, 32'h100};
        m_wdata  = {32'h2222_2222, 32'h1111_1111};
        m_awvalid = 2'b11; m_wvalid = 2'b11; m_bready = 2'b11;
        s_bvalid = 1'b1;
        for (int t = 0; t < 6; t++) begin
            step();
            chk("rr_gnt", wr_gnt, 64'd1 << exp_seq[t]);
            chk("rr_addr", s_awaddr, (exp_seq[t] == 0) ? 32'h100 : 32'h200);
            step();
            chk("rr_bvalid", m_bvalid, 64'd1 << exp_seq[t]);
            step();
            rem[exp_seq[t]]--;
            if (rem[exp_seq[t]] == 0) begin
                if (exp_seq[t] == 0) begin
                    m_awvalid[0] = 1'b0; m_wvalid[0] = 1'b0;
                end else begin
                    m_awvalid[1] = 1'b0; m_wvalid[1] = 1'b0;
                end
            end
        end
        s_bvalid = 1'b0;
        step();
        chk("rr_done_gnt", wr_gnt, 2'b00);

        // Concurrent read from M0 and write from M1; W accepted before AW
        m_araddr[31:0]  = 32'h20;
        m_awaddr[63:32] = 32'h30;
        m_wdata[63:32]  = 32'h1234_5678;
        m_arvalid = 2'b01; m_rready = 2'b01;
        m_awvalid = 2'b10; m_wvalid = 2'b10; m_bready = 2'b10;
        s_awready = 1'b0; s_wready = 1'b1; s_arready = 1'b1;
        step();
        chk("cc_gnts", {rd_gnt, wr_gnt}, 4'b0110);
        chk("cc_s_araddr", s_araddr, 32'h20);
        chk("cc_m_arready", m_arready, 2'b01);
        chk("cc_aw_stall", {s_awvalid, m_awready, m_wready}, 5'b1_00_10);
        step();
        m_arvalid = 2'b00; m_wvalid = 2'b00;
        s_rvalid = 1'b1; s_rdata = 32'hCAFE_F00D; s_rresp = 2'b00;
        #1;
        chk("cc_w_done", {s_wvalid, s_awvalid, m_wready}, 4'b0100);
        chk("cc_m_rvalid", m_rvalid, 2'b01);
        chk("cc_m_rdata", m_rdata, 64'hCAFEF00D_CAFEF00D);
        chk("cc_s_rready", s_rready, 1'b1);
        step();
        s_rvalid = 1'b0;
        #1;
        chk("cc_rd_idle", {rd_gnt, m_rvalid}, 4'b0);
        chk("cc_wr_held", wr_gnt, 2'b10);
        step();
        s_awready = 1'b1;
        #1;
        chk("cc_m_awready", m_awready, 2'b10);
        step();
        m_awvalid = 2'b00;
        s_bvalid = 1'b1; s_bresp = 2'b10;
        #1;
        chk("cc_m_bvalid", {m_bvalid, m_rvalid}, 4'b1000);
        chk("cc_bresp", m_bresp, 4'b1010);
        step();
        s_bvalid = 1'b0; s_bresp = 2'b00;
        #1;
        chk("cc_wr_idle", wr_gnt, 2'b00);

        // M0 write moves the pointer to 1
        m_awvalid = 2'b01; m_wvalid = 2'b01; m_bready = 2'b01;
        step();
        step();
        m_awvalid = 2'b00; m_wvalid = 2'b00;
        s_bvalid = 1'b1;
        step();
        s_bvalid = 1'b0;
        // Lone requester M0 is granted despite ptr=1 (round robin)
        m_awvalid = 2'b01; m_wvalid = 2'b01;
        step();
        chk("single_gnt", wr_gnt, 2'b01);
        step();
        m_awvalid = 2'b00; m_wvalid = 2'b00;
        s_bvalid = 1'b1;
        #1;
        chk("pre_rst_bvalid", m_bvalid, 2'b01);
        rst_n = 1'b0;
        m_awvalid = 2'b11; m_wvalid = 2'b11;
        #1;
        chk("mid_rst_bvalid", m_bvalid, 2'b00);
        chk("mid_rst_gnt", wr_gnt, 2'b00);
        step();
        rst_n = 1'b1;
        s_bvalid = 1'b0;
        step();
        chk("post_rst_gnt", wr_gnt, 2'b01);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
